// File: rtl/twiddle_sequencer.sv
// Walks every butterfly of an N-point radix-2 DIF FFT, addresses the twiddle ROM and
// streams {idx_a, idx_b, stage, twiddle, last} to the butterfly datapath over valid/ready.
module twiddle_sequencer #(
    parameter int N_LOG2  = 10,
    parameter int ROM_LEN = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [15:0]         rom_addr,
    input  logic signed [15:0]  rom_w_re,
    input  logic signed [15:0]  rom_w_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [15:0]  out_w_re,
    output logic signed [15:0]  out_w_im,
    output logic [N_LOG2-1:0]   out_idx_a,
    output logic [N_LOG2-1:0]   out_idx_b,
    output logic [3:0]          out_stage,
    output logic                out_last
);

    // state | meaning
    // IDLE  | waiting for start; first entry is loaded into P1 on acceptance
    // RUN   | entries flow P1 -> OUT; leaves when the last entry is accepted
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [N_LOG2-1:0] ONE   = N_LOG2'(1);
    localparam logic [N_LOG2-1:0] K_MAX = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
    localparam logic [3:0]        S_MAX = 4'(N_LOG2 - 1);

    if (N_LOG2 < 1 || N_LOG2 > 15) begin : g_bad_n_log2
        $error("twiddle_sequencer: N_LOG2 must be in 1..15");
    end
    if (ROM_LEN != (1 << (N_LOG2 - 1))) begin : g_bad_rom_len
        $error("twiddle_sequencer: ROM_LEN must equal N/2");
    end

    state_t            state;
    logic [3:0]        s_cnt;
    logic [N_LOG2-1:0] k_cnt;

    logic              p1_valid;
    logic              p1_last;
    logic [N_LOG2-1:0] p1_idx_a;
    logic [N_LOG2-1:0] p1_idx_b;
    logic [3:0]        p1_stage;

    logic [3:0]        g_s;
    logic [3:0]        g_sh;
    logic [N_LOG2-1:0] g_k;
    logic [N_LOG2-1:0] g_span;
    logic [N_LOG2-1:0] g_j;
    logic [N_LOG2-1:0] g_grp;
    logic [N_LOG2-1:0] g_idx_a;
    logic [N_LOG2-1:0] g_idx_b;
    logic [N_LOG2-1:0] g_addr;
    logic              g_last;
    logic              adv;
    logic              more;

    // (s_cnt, k_cnt) is the entry currently in P1; g_* is the entry that follows it.
    // span is a power of two, so mod/div reduce to a mask and a shift by (N_LOG2-1-s).
    always_comb begin
        g_s = s_cnt;
        g_k = k_cnt + ONE;
        if (state == IDLE) begin
            g_s = '0;
            g_k = '0;
        end else if (k_cnt == K_MAX) begin
            g_s = s_cnt + 4'd1;
            g_k = '0;
        end
        g_sh    = S_MAX - g_s;
        g_span  = ONE << g_sh;
        g_j     = g_k & (g_span - ONE);
        g_grp   = g_k >> g_sh;
        g_idx_a = ((g_grp << 1) << g_sh) | g_j;
        g_idx_b = g_idx_a | g_span;
        g_addr  = g_j << g_s;
        g_last  = (g_s == S_MAX) && (g_k == K_MAX);
    end

    assign adv  = !out_valid || out_ready;
    assign more = p1_valid && !p1_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            s_cnt     <= '0;
            k_cnt     <= '0;
            p1_valid  <= 1'b0;
            p1_last   <= 1'b0;
            p1_idx_a  <= '0;
            p1_idx_b  <= '0;
            p1_stage  <= '0;
            rom_addr  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_w_re  <= '0;
            out_w_im  <= '0;
            out_idx_a <= '0;
            out_idx_b <= '0;
            out_stage <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // a start coinciding with the done pulse is dropped
                    if (start && !done) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        s_cnt    <= g_s;
                        k_cnt    <= g_k;
                        p1_valid <= 1'b1;
                        p1_last  <= g_last;
                        p1_idx_a <= g_idx_a;
                        p1_idx_b <= g_idx_b;
                        p1_stage <= g_s;
                        rom_addr <= 16'(g_addr);
                    end
                end
                RUN: begin
                    if (adv) begin
                        out_valid <= p1_valid;
                        out_last  <= p1_last;
                        out_idx_a <= p1_idx_a;
                        out_idx_b <= p1_idx_b;
                        out_stage <= p1_stage;
                        out_w_re  <= rom_w_re;
                        out_w_im  <= rom_w_im;
                        if (more) begin
                            s_cnt    <= g_s;
                            k_cnt    <= g_k;
                            p1_last  <= g_last;
                            p1_idx_a <= g_idx_a;
                            p1_idx_b <= g_idx_b;
                            p1_stage <= g_s;
                            rom_addr <= 16'(g_addr);
                        end else begin
                            p1_valid <= 1'b0;
                        end
                    end
                    if (out_valid && out_ready && out_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Bench for twiddle_sequencer: N=8 and N=1024 instances, random backpressure,
// checked against an arithmetic model of the butterfly walk.
module tb_twiddle_sequencer;

    typedef struct {
        int s;
        int a;
        int b;
        int addr;
    } ent_t;
    typedef ent_t ent_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start3, ready3, start10, ready10;

    logic               busy3, done3, v3, last3;
    logic [15:0]        a3_addr;
    logic signed [15:0] r3_re, r3_im, w3_re, w3_im;
    logic [2:0]         ia3, ib3;
    logic [3:0]         st3;

    logic               busy10, done10, v10, last10;
    logic [15:0]        a10_addr;
    logic signed [15:0] r10_re, r10_im, w10_re, w10_im;
    logic [9:0]         ia10, ib10;
    logic [3:0]         st10;

    assign r3_re  = 16'(100 + int'(a3_addr));
    assign r3_im  = 16'(-int'(a3_addr));
    assign r10_re = 16'(100 + int'(a10_addr));
    assign r10_im = 16'(-int'(a10_addr));

    twiddle_sequencer #(.N_LOG2(3), .ROM_LEN(4)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .rom_addr(a3_addr), .rom_w_re(r3_re), .rom_w_im(r3_im),
        .out_valid(v3), .out_ready(ready3), .out_w_re(w3_re), .out_w_im(w3_im),
        .out_idx_a(ia3), .out_idx_b(ib3), .out_stage(st3), .out_last(last3)
    );

    twiddle_sequencer #(.N_LOG2(10), .ROM_LEN(512)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .busy(busy10), .done(done10),
        .rom_addr(a10_addr), .rom_w_re(r10_re), .rom_w_im(r10_im),
        .out_valid(v10), .out_ready(ready10), .out_w_re(w10_re), .out_w_im(w10_im),
        .out_idx_a(ia10), .out_idx_b(ib10), .out_stage(st10), .out_last(last10)
    );

    int checks = 0;
    int errors = 0;
    ent_q_t exp3;
    ent_q_t exp10;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic ent_q_t gen(input int nl);
        ent_q_t q;
        ent_t   e;
        int     n;
        int     span;
        int     j;
        int     g;
        n = 1 << nl;
        for (int s = 0; s < nl; s++) begin
            for (int k = 0; k < n / 2; k++) begin
                span   = n >> (s + 1);
                j      = k % span;
                g      = k / span;
                e.s    = s;
                e.a    = 2 * g * span + j;
                e.b    = e.a + span;
                e.addr = j << s;
                q.push_back(e);
            end
        end
        return q;
    endfunction

    // rnd: random out_ready; pulse_start: extra start mid-run and on the done cycle;
    // rst_after: abort with rst after that many handshakes; hold0: out_ready low until that cycle
    task automatic run3(input string nm, input bit rnd, input bit pulse_start,
                        input int rst_after, input int hold0);
        int          got = 0;
        int          cyc = 1;
        bit          last_hs = 0;
        bit          fin = 0;
        bit          stalled = 0;
        logic [10:0] snap_idx;
        logic [31:0] snap_w;
        ent_t        e;

        @(negedge clk);
        start3 = 1'b1;
        ready3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk({nm, "/busy_c1"},  busy3,   1);
        chk({nm, "/valid_c1"}, v3,      0);
        chk({nm, "/addr_c1"},  a3_addr, 0);

        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start3 = pulse_start && (cyc == 6);
            if (cyc == 2) chk({nm, "/valid_c2"}, v3, 1);
            if (stalled) begin
                chk({nm, "/stable_idx"}, {st3, ia3, ib3, last3}, snap_idx);
                chk({nm, "/stable_w"},   {w3_re, w3_im},         snap_w);
            end
            if (last_hs) begin
                chk({nm, "/done"},      done3, 1);
                chk({nm, "/busy_done"}, busy3, 1);
                if (pulse_start) start3 = 1'b1;
                @(negedge clk);
                start3 = 1'b0;
                chk({nm, "/busy_after"},  busy3, 0);
                chk({nm, "/done_after"},  done3, 0);
                chk({nm, "/valid_after"}, v3,    0);
                fin = 1;
            end else begin
                chk({nm, "/no_done"}, done3, 0);
                if (cyc < hold0) ready3 = 1'b0;
                else             ready3 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (hold0 > 0 && cyc < hold0) begin
                    chk({nm, "/hold_addr"},  a3_addr, 1);
                    chk({nm, "/hold_valid"}, v3,      1);
                    chk({nm, "/hold_a"},     ia3,     0);
                    chk({nm, "/hold_b"},     ib3,     4);
                end
                if (!rnd && hold0 == 0 && got > 0 && got < 12) chk({nm, "/no_bubble"}, v3, 1);
                stalled = v3 && !ready3;
                snap_idx = {st3, ia3, ib3, last3};
                snap_w   = {w3_re, w3_im};
                if (v3 && ready3) begin
                    if (got >= 12) begin
                        chk({nm, "/overrun"}, got, 11);
                    end else begin
                        e = exp3[got];
                        chk({nm, "/stage"}, st3,   e.s);
                        chk({nm, "/idx_a"}, ia3,   e.a);
                        chk({nm, "/idx_b"}, ib3,   e.b);
                        chk({nm, "/w_re"},  w3_re, 100 + e.addr);
                        chk({nm, "/w_im"},  w3_im, -e.addr);
                        chk({nm, "/last"},  last3, (got == 11) ? 1 : 0);
                    end
                    got++;
                    last_hs = (got == 12);
                    if (rst_after > 0 && got == rst_after) break;
                end
            end
        end

        if (rst_after > 0) begin
            @(negedge clk);
            rst    = 1'b1;
            ready3 = 1'b0;
            @(negedge clk);
            chk({nm, "/rst_busy"},  busy3,   0);
            chk({nm, "/rst_done"},  done3,   0);
            chk({nm, "/rst_valid"}, v3,      0);
            chk({nm, "/rst_last"},  last3,   0);
            chk({nm, "/rst_addr"},  a3_addr, 0);
            chk({nm, "/rst_w_re"},  w3_re,   0);
            chk({nm, "/rst_w_im"},  w3_im,   0);
            chk({nm, "/rst_a"},     ia3,     0);
            chk({nm, "/rst_b"},     ib3,     0);
            chk({nm, "/rst_stage"}, st3,     0);
            rst = 1'b0;
            repeat (8) begin
                @(negedge clk);
                chk({nm, "/post_rst_done"},  done3, 0);
                chk({nm, "/post_rst_valid"}, v3,    0);
            end
        end else begin
            chk({nm, "/finished"}, fin, 1);
            chk({nm, "/count"},    got, 12);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run10();
        int   got = 0;
        int   cyc = 0;
        bit   last_hs = 0;
        bit   fin = 0;
        ent_t e;

        @(negedge clk);
        start10 = 1'b1;
        ready10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        while (!fin && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            chk("n10/addr_lt_512", (a10_addr < 16'd512) ? 1 : 0, 1);
            chk("n10/done", done10, last_hs ? 1 : 0);
            if (last_hs) begin
                fin = 1;
            end else begin
                if (v10 && ready10) begin
                    if (got >= 5120) begin
                        chk("n10/overrun", got, 5119);
                    end else begin
                        e = exp10[got];
                        chk("n10/stage", st10,   e.s);
                        chk("n10/idx_a", ia10,   e.a);
                        chk("n10/idx_b", ib10,   e.b);
                        chk("n10/w_re",  w10_re, 100 + e.addr);
                        chk("n10/w_im",  w10_im, -e.addr);
                        chk("n10/last",  last10, (got == 5119) ? 1 : 0);
                    end
                    if (got == 5119) begin
                        chk("n10/final_stage", st10,   9);
                        chk("n10/final_a",     ia10,   1022);
                        chk("n10/final_b",     ib10,   1023);
                        chk("n10/final_w_re",  w10_re, 100);
                        chk("n10/final_last",  last10, 1);
                    end
                    got++;
                    last_hs = (got == 5120);
                end else if (got > 0) begin
                    chk("n10/no_bubble", v10, 1);
                end
            end
        end
        chk("n10/finished", fin, 1);
        chk("n10/count",    got, 5120);
    endtask

    initial begin
        exp3    = gen(3);
        exp10   = gen(10);
        rst     = 1'b1;
        start3  = 1'b0;
        ready3  = 1'b0;
        start10 = 1'b0;
        ready10 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/busy",  busy3,   0);
        chk("reset/done",  done3,   0);
        chk("reset/valid", v3,      0);
        chk("reset/last",  last3,   0);
        chk("reset/addr",  a3_addr, 0);
        chk("reset/w_re",  w3_re,   0);
        chk("reset/stage", st3,     0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run3("t1_ready",      0, 0, 0, 0);
        run3("t2_random",     1, 0, 0, 0);
        run3("t3_restart",    1, 1, 0, 0);
        run3("t4_abort",      1, 0, 5, 0);
        run3("t4_resume",     0, 0, 0, 0);
        run3("t6_hold",       0, 0, 0, 20);
        run3("t2_random_b",   1, 0, 0, 0);
        run10();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
